// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch PC generator.
// State encoding is visible on state_o, so values are fixed.
package pc_gen_pkg;

    localparam int PC_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // True when the low align_bits bits of addr are all zero.
    function automatic logic is_aligned(
        input logic [63:0] addr,
        input int          align_bits
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < align_bits && addr[i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Next-PC priority mux with alignment check on jump/branch targets.
// Purely combinational; all state lives in pc_gen_unit.
module pc_redirect_sel
    import pc_gen_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int ALIGN_BITS = 2
) (
    input  logic [PC_WIDTH-1:0] seq_pc,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                trap,
    input  logic [PC_WIDTH-1:0] trap_vec,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                hold,
    output logic                misalign,
    output logic [PC_WIDTH-1:0] bad_target
);

    // Trap beats stall; a stalled jump/branch is dropped, not checked.
    always_comb begin
        next_pc    = seq_pc;
        hold       = 1'b0;
        misalign   = 1'b0;
        bad_target = '0;
        priority case (1'b1)
            trap: begin
                next_pc = trap_vec;
            end
            stall: begin
                hold = 1'b1;
            end
            jump: begin
                if (is_aligned(64'(jump_target), ALIGN_BITS)) begin
                    next_pc = jump_target;
                end else begin
                    hold       = 1'b1;
                    misalign   = 1'b1;
                    bad_target = jump_target;
                end
            end
            br_taken: begin
                if (is_aligned(64'(br_target), ALIGN_BITS)) begin
                    next_pc = br_target;
                end else begin
                    hold       = 1'b1;
                    misalign   = 1'b1;
                    bad_target = br_target;
                end
            end
            default: begin
                next_pc = seq_pc;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register with boot wait, halt/resume and redirect handling.
// Drives the instruction SRAM address and its valid qualifier.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int                PC_WIDTH    = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = '0,
    parameter int                BOOT_CYCLES = 2,
    parameter int                ALIGN_BITS  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                br_taken_i,
    input  logic [PC_WIDTH-1:0] br_target_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    input  logic                trap_i,
    input  logic [PC_WIDTH-1:0] trap_vec_i,
    input  logic                halt_i,
    input  logic                resume_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_plus4_o,
    output logic                fetch_valid_o,
    output logic                misalign_o,
    output logic [PC_WIDTH-1:0] misalign_addr_o,
    output logic [1:0]          state_o
);

    localparam int CNT_W =
        (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST =
        CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam pc_state_e RESET_STATE =
        (BOOT_CYCLES == 0) ? RUN : BOOT;

    pc_state_e           state;
    logic [CNT_W-1:0]    boot_cnt;
    logic [PC_WIDTH-1:0] pc;
    logic                misalign;
    logic [PC_WIDTH-1:0] misalign_addr;

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] sel_next;
    logic                sel_hold;
    logic                sel_mis;
    logic [PC_WIDTH-1:0] sel_bad;

    assign pc_plus4 = pc + PC_WIDTH'(4);

    pc_redirect_sel #(
        .PC_WIDTH   (PC_WIDTH),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_sel (
        .seq_pc      (pc_plus4),
        .stall       (stall_i),
        .br_taken    (br_taken_i),
        .br_target   (br_target_i),
        .jump        (jump_i),
        .jump_target (jump_target_i),
        .trap        (trap_i),
        .trap_vec    (trap_vec_i),
        .next_pc     (sel_next),
        .hold        (sel_hold),
        .misalign    (sel_mis),
        .bad_target  (sel_bad)
    );

    // Boot wait, run/halt control and PC/misalign registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= RESET_STATE;
            boot_cnt      <= '0;
            pc            <= RESET_VEC;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state <= RUN;
                    end else begin
                        boot_cnt <= boot_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!sel_hold) pc <= sel_next;
                    if (sel_mis) begin
                        misalign      <= 1'b1;
                        misalign_addr <= sel_bad;
                    end
                    if (halt_i && !trap_i) state <= HALT;
                end
                HALT: begin
                    if (trap_i) begin
                        pc    <= trap_vec_i;
                        state <= RUN;
                    end else if (resume_i) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RESET_STATE;
                end
            endcase
        end
    end

    assign pc_o            = pc;
    assign pc_plus4_o      = pc_plus4;
    assign fetch_valid_o   = (state == RUN) && !stall_i;
    assign misalign_o      = misalign;
    assign misalign_addr_o = misalign_addr;
    assign state_o         = state;

endmodule
